// File: rtl/ex_mdu_if.sv
// Handshake/data bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives the launch request and operands; the slave returns status and HI/LO data.
interface ex_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, a, b,
        input  busy, mdu_out, hi, lo
    );

    modport slave (
        input  start, mdu_op, a, b,
        output busy, mdu_out, hi, lo
    );
endinterface

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO and computes the result at launch.
// The result is held in shadow registers and committed after a fixed busy latency.
//
// state  | meaning
// S_IDLE | no operation in flight; accepts launches and MTHI/MTLO
// S_RUN  | operation in flight; counter runs down, commits when it reaches 1
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    ex_mdu_if.slave  bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           r_state;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_n;
    logic [31:0]      r_lo_n;
    logic             r_dz;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_md;
    logic             w_launch;
    logic signed [63:0] w_prod_s;
    logic [63:0]      w_prod_u;
    logic             w_b_zero;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_sden;
    logic [31:0]      w_uden;
    logic [31:0]      w_sq_mag;
    logic [31:0]      w_sr_mag;
    logic [31:0]      w_sq;
    logic [31:0]      w_sr;
    logic [31:0]      w_uq;
    logic [31:0]      w_ur;
    logic [31:0]      w_hi_calc;
    logic [31:0]      w_lo_calc;
    logic [CNT_W-1:0] w_cnt_ld;
    logic             w_dz;
    logic [31:0]      w_mdu_out;

    assign w_is_md  = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                      (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
    assign w_launch = (r_state == S_IDLE) && bus.start && w_is_md;

    assign w_prod_s = 64'($signed(bus.a)) * 64'($signed(bus.b));
    assign w_prod_u = 64'(bus.a) * 64'(bus.b);

    // Signed divide on magnitudes: 0x80000000 keeps its bit pattern as an unsigned
    // magnitude, so the overflow case falls out as quotient 0x80000000, remainder 0.
    assign w_b_zero = (bus.b == 32'd0);
    assign w_a_mag  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign w_b_mag  = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    assign w_sden   = w_b_zero ? 32'd1 : w_b_mag;
    assign w_uden   = w_b_zero ? 32'd1 : bus.b;
    assign w_sq_mag = w_a_mag / w_sden;
    assign w_sr_mag = w_a_mag % w_sden;
    assign w_sq     = (bus.a[31] ^ bus.b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = bus.a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = bus.a / w_uden;
    assign w_ur     = bus.a % w_uden;

    always_comb begin
        w_hi_calc = 32'd0;
        w_lo_calc = 32'd0;
        w_cnt_ld  = MULT_LD;
        w_dz      = 1'b0;
        case (bus.mdu_op)
            OP_MULT: begin
                w_hi_calc = w_prod_s[63:32];
                w_lo_calc = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_hi_calc = w_prod_u[63:32];
                w_lo_calc = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_hi_calc = w_sr;
                w_lo_calc = w_sq;
                w_cnt_ld  = DIV_LD;
                w_dz      = w_b_zero;
            end
            OP_DIVU: begin
                w_hi_calc = w_ur;
                w_lo_calc = w_uq;
                w_cnt_ld  = DIV_LD;
                w_dz      = w_b_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_n  <= 32'd0;
            r_lo_n  <= 32'd0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_hi_n  <= w_hi_calc;
                        r_lo_n  <= w_lo_calc;
                        r_dz    <= w_dz;
                        r_cnt   <= w_cnt_ld;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else if (!bus.start && bus.mdu_op == OP_MTHI) begin
                        r_hi <= bus.a;
                    end else if (!bus.start && bus.mdu_op == OP_MTLO) begin
                        r_lo <= bus.a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        if (!r_dz) begin
                            r_hi <= r_hi_n;
                            r_lo <= r_lo_n;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_mdu_out = 32'd0;
        if (bus.mdu_op == OP_MFHI)
            w_mdu_out = r_hi;
        else if (bus.mdu_op == OP_MFLO)
            w_mdu_out = r_lo;
    end

    assign bus.busy    = r_busy;
    assign bus.mdu_out = w_mdu_out;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: the stimulus side queues expected commits and reads,
// and a negedge monitor pops and compares whenever busy falls or MFHI/MFLO is presented.
module tb_ex_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mdu_if mif ();

    ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } commit_t;

    commit_t     q_commit[$];
    logic [31:0] q_read[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares commits when busy falls and read data when MFHI/MFLO is on the bus.
    int  busy_len  = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (mif.busy) busy_len++;
            if (prev_busy && !mif.busy) begin
                if (q_commit.size() == 0) begin
                    chk("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    commit_t e;
                    e = q_commit.pop_front();
                    chk("commit_hi", mif.hi, e.hi);
                    chk("commit_lo", mif.lo, e.lo);
                    chk("busy_cycles", busy_len, e.len);
                end
                busy_len = 0;
            end
            prev_busy = mif.busy;
            if (mif.mdu_op == 4'd5 || mif.mdu_op == 4'd6) begin
                if (q_read.size() == 0)
                    chk("unexpected_read", 64'd1, 64'd0);
                else
                    chk(mif.mdu_op == 4'd5 ? "mfhi" : "mflo", mif.mdu_out, q_read.pop_front());
            end else begin
                chk("mdu_out_idle_zero", mif.mdu_out, 64'd0);
            end
        end
    end

    // Reference arithmetic from plain 64-bit integer math; b==0 divides leave HI/LO alone.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit keep);
        longint      p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] u;
        logic [31:0] nh;
        logic [31:0] nl;
        int          len;
        commit_t     e;
        nh  = m_hi;
        nl  = m_lo;
        len = MC;
        case (op)
            4'd1: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                nh = p[63:32];
                nl = p[31:0];
            end
            4'd2: begin
                u  = {32'd0, a} * {32'd0, b};
                nh = u[63:32];
                nl = u[31:0];
            end
            4'd3: begin
                len = DC;
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    nh = r[31:0];
                    nl = q[31:0];
                end
            end
            default: begin
                len = DC;
                if (b != 32'd0) begin
                    nh = a % b;
                    nl = a / b;
                end
            end
        endcase
        mif.start  = 1'b1;
        mif.mdu_op = op;
        mif.a      = a;
        mif.b      = b;
        @(posedge clk); #1;
        mif.start  = 1'b0;
        mif.mdu_op = 4'd0;
        if (keep) begin
            e.hi  = nh;
            e.lo  = nl;
            e.len = len;
            q_commit.push_back(e);
            m_hi = nh;
            m_lo = nl;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && mif.busy; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_timeout", mif.busy, 64'd0);
    endtask

    task automatic rd(input bit h);
        mif.mdu_op = h ? 4'd5 : 4'd6;
        q_read.push_back(h ? m_hi : m_lo);
        @(posedge clk); #1;
        mif.mdu_op = 4'd0;
    endtask

    task automatic mt(input bit h, input logic [31:0] v);
        mif.mdu_op = h ? 4'd7 : 4'd8;
        mif.a      = v;
        @(posedge clk); #1;
        mif.mdu_op = 4'd0;
        if (h) m_hi = v;
        else   m_lo = v;
    endtask

    function automatic logic [31:0] rand_val(input bit allow_zero);
        case ($urandom_range(0, 7))
            0:       return allow_zero ? 32'd0 : 32'd3;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] iop;
        mif.start  = 1'b0;
        mif.mdu_op = 4'd0;
        mif.a      = 32'd0;
        mif.b      = 32'd0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", mif.busy, 64'd0);
        chk("reset_hi", mif.hi, 64'd0);
        chk("reset_lo", mif.lo, 64'd0);
        rd(1);
        rd(0);

        launch(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle();
        rd(1);
        chk("mult_hi_const", mif.hi, 64'hFFFF_FFFF);
        chk("mult_lo_const", mif.lo, 64'hFFFF_FFFE);

        launch(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("multu_hi_const", mif.hi, 64'hFFFF_FFFE);
        chk("multu_lo_const", mif.lo, 64'h0000_0001);

        launch(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        rd(0);
        chk("div_lo_const", mif.lo, 64'hFFFF_FFFD);
        chk("div_hi_const", mif.hi, 64'hFFFF_FFFF);
        launch(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        chk("divu_lo_const", mif.lo, 64'h7FFF_FFFC);
        chk("divu_hi_const", mif.hi, 64'd1);

        mt(1, 32'h1234);
        rd(1);
        launch(4'd3, 32'd5, 32'd0, 1'b1);
        wait_idle();
        rd(1);
        rd(0);
        chk("dz_hi_const", mif.hi, 64'h1234);

        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("div_ovf_lo_const", mif.lo, 64'h8000_0000);
        chk("div_ovf_hi_const", mif.hi, 64'd0);

        // Second start and MTLO while busy must both be ignored.
        launch(4'd1, 32'd3, 32'd4, 1'b1);
        mif.start  = 1'b1;
        mif.mdu_op = 4'd1;
        mif.a      = 32'd5;
        mif.b      = 32'd5;
        @(posedge clk); #1;
        mif.start  = 1'b0;
        mif.mdu_op = 4'd8;
        mif.a      = 32'hAA;
        @(posedge clk); #1;
        mif.mdu_op = 4'd0;
        wait_idle();
        rd(0);
        chk("busy_ignore_lo_const", mif.lo, 64'd12);

        // Reset in busy cycle 3 aborts the operation.
        launch(4'd1, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", mif.busy, 64'd0);
        chk("abort_hi", mif.hi, 64'd0);
        chk("abort_lo", mif.lo, 64'd0);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("abort_no_busy", mif.busy, 64'd0);
        rd(1);
        rd(0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    iop = 4'($urandom_range(1, 4));
                    launch(iop, rand_val(1'b0), rand_val(1'b1), 1'b1);
                    wait_idle();
                    rd(1);
                    rd(0);
                end
                4: begin mt(1, $urandom); rd(1); end
                5: begin mt(0, $urandom); rd(0); end
                6: begin
                    case ($urandom_range(0, 3))
                        0:       iop = 4'd0;
                        1:       iop = 4'd7;
                        2:       iop = 4'd8;
                        default: iop = 4'($urandom_range(9, 15));
                    endcase
                    mif.start  = 1'b1;
                    mif.mdu_op = iop;
                    mif.a      = $urandom;
                    mif.b      = $urandom;
                    @(posedge clk); #1;
                    mif.start  = 1'b0;
                    mif.mdu_op = 4'd0;
                    chk("ignored_start_busy", mif.busy, 64'd0);
                    rd(1);
                    rd(0);
                end
                default: rd(1'($urandom_range(0, 1)));
            endcase
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("commit_queue_empty", q_commit.size(), 64'd0);
        chk("read_queue_empty", q_read.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
